// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: operation codes, FSM states and
// the iteration-core mode encoding.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_MULS = 3'b010,
        OP_MULU = 3'b011,
        OP_DIVU = 3'b100,
        OP_SHL  = 3'b101,
        OP_SHR  = 3'b110,
        OP_SAR  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_ITER = 2'b01,
        S_DONE = 2'b10
    } state_e;

    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_DIV = 1'b1;

    function automatic logic is_mul(input op_e op);
        return (op == OP_MULS) || (op == OP_MULU);
    endfunction

endpackage

// File: rtl/alu_iter_core.sv
// Shared WIDTH-step datapath: shift-add unsigned multiply and restoring
// divide. acc holds the partial product / remainder, sr the low product / quotient.
module alu_iter_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             mode,
    input  logic             step,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             last,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] acc_q, acc_d, sr_q, sr_d, opb_q, opb_d;
    logic             mode_q, mode_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   mul_sum_s, div_rem_s, div_diff_s;

    // Next-state for one multiply or divide step.
    always_comb begin
        mul_sum_s  = {1'b0, acc_q} + {1'b0, (sr_q[0] ? opb_q : {WIDTH{1'b0}})};
        div_rem_s  = {acc_q, sr_q[WIDTH-1]};
        div_diff_s = div_rem_s - {1'b0, opb_q};
        acc_d  = acc_q;
        sr_d   = sr_q;
        opb_d  = opb_q;
        mode_d = mode_q;
        cnt_d  = cnt_q;
        if (load) begin
            acc_d  = {WIDTH{1'b0}};
            sr_d   = opa;
            opb_d  = opb;
            mode_d = mode;
            cnt_d  = {CW{1'b0}};
        end else if (step) begin
            if (mode_q == MODE_MUL) begin
                acc_d = mul_sum_s[WIDTH:1];
                sr_d  = {mul_sum_s[0], sr_q[WIDTH-1:1]};
            // a clear top bit of the difference means the trial subtract fits
            end else if (!div_diff_s[WIDTH]) begin
                acc_d = div_diff_s[WIDTH-1:0];
                sr_d  = {sr_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = div_rem_s[WIDTH-1:0];
                sr_d  = {sr_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Iteration registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= {WIDTH{1'b0}};
            sr_q   <= {WIDTH{1'b0}};
            opb_q  <= {WIDTH{1'b0}};
            mode_q <= MODE_MUL;
            cnt_q  <= {CW{1'b0}};
        end else begin
            acc_q  <= acc_d;
            sr_q   <= sr_d;
            opb_q  <= opb_d;
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
        end
    end

    assign last = (cnt_q == CW'(WIDTH - 1));
    assign hi   = acc_q;
    assign lo   = sr_q;

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU with start/done handshake: control FSM, single-cycle ops,
// multiply sign correction and flag generation around alu_iter_core.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             div_by_zero
);

    state_e           state_q, state_d;
    op_e              op_q, op_d, op_in_s;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, lo_q, lo_d, hi_q, hi_d;
    logic             cin_q, cin_d, neg_q, neg_d, busy_q, busy_d, done_q, done_d;
    logic             carry_q, carry_d, ovf_q, ovf_d, zero_q, zero_d, dbz_q, dbz_d;

    logic             it_load_s, it_step_s, it_mode_s, it_last_s;
    logic [WIDTH-1:0] it_opa_s, it_opb_s, it_hi_s, it_lo_s;
    logic [WIDTH-1:0] res_lo_s, res_hi_s;
    logic             res_c_s, res_v_s, res_z_s, res_dz_s;
    logic [WIDTH:0]   sum_s, diff_s;
    logic [2*WIDTH-1:0] prod_s, sprod_s;

    assign op_in_s = op_e'(op);

    alu_iter_core #(.WIDTH(WIDTH)) u_iter (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (it_load_s),
        .mode  (it_mode_s),
        .step  (it_step_s),
        .opa   (it_opa_s),
        .opb   (it_opb_s),
        .last  (it_last_s),
        .hi    (it_hi_s),
        .lo    (it_lo_s)
    );

    // Result and flag computation from the latched operands, used in DONE.
    always_comb begin
        sum_s   = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
        diff_s  = {1'b0, a_q} - {1'b0, b_q};
        prod_s  = {it_hi_s, it_lo_s};
        sprod_s = neg_q ? (~prod_s + {{(2*WIDTH-1){1'b0}}, 1'b1}) : prod_s;
        res_lo_s = {WIDTH{1'b0}};
        res_hi_s = {WIDTH{1'b0}};
        res_c_s  = 1'b0;
        res_v_s  = 1'b0;
        res_dz_s = 1'b0;
        case (op_q)
            OP_ADD: begin
                res_lo_s = sum_s[WIDTH-1:0];
                res_c_s  = sum_s[WIDTH];
                res_v_s  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_s[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                res_lo_s = diff_s[WIDTH-1:0];
                res_c_s  = diff_s[WIDTH];
                res_v_s  = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_s[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_MULS: begin
                {res_hi_s, res_lo_s} = sprod_s;
                res_v_s = (sprod_s[2*WIDTH-1:WIDTH] != {WIDTH{sprod_s[WIDTH-1]}});
            end
            OP_MULU: begin
                {res_hi_s, res_lo_s} = prod_s;
                res_v_s = (it_hi_s != {WIDTH{1'b0}});
            end
            OP_DIVU: begin
                if (b_q == {WIDTH{1'b0}}) begin
                    res_lo_s = {WIDTH{1'b1}};
                    res_hi_s = a_q;
                    res_dz_s = 1'b1;
                end else begin
                    res_lo_s = it_lo_s;
                    res_hi_s = it_hi_s;
                end
            end
            OP_SHL:  res_lo_s = a_q << b_q;
            OP_SHR:  res_lo_s = a_q >> b_q;
            OP_SAR:  res_lo_s = $signed(a_q) >>> b_q;
            default: res_lo_s = {WIDTH{1'b0}};
        endcase
        if (is_mul(op_q)) begin
            res_z_s = ({res_hi_s, res_lo_s} == {(2*WIDTH){1'b0}});
        end else begin
            res_z_s = (res_lo_s == {WIDTH{1'b0}});
        end
    end

    // Control FSM, operand capture and output register next-state.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        cin_d   = cin_q;
        neg_d   = neg_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        lo_d    = lo_q;
        hi_d    = hi_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        dbz_d   = dbz_q;
        it_load_s = 1'b0;
        it_step_s = 1'b0;
        it_mode_s = (op_in_s == OP_DIVU) ? MODE_DIV : MODE_MUL;
        // signed multiply runs on magnitudes; the sign is restored in DONE
        if (op_in_s == OP_MULS) begin
            it_opa_s = a[WIDTH-1] ? (~a + {{(WIDTH-1){1'b0}}, 1'b1}) : a;
            it_opb_s = b[WIDTH-1] ? (~b + {{(WIDTH-1){1'b0}}, 1'b1}) : b;
        end else begin
            it_opa_s = a;
            it_opb_s = b;
        end
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d   = op_in_s;
                    a_d    = a;
                    b_d    = b;
                    cin_d  = cin;
                    neg_d  = a[WIDTH-1] ^ b[WIDTH-1];
                    busy_d = 1'b1;
                    if (is_mul(op_in_s) || ((op_in_s == OP_DIVU) && (b != {WIDTH{1'b0}}))) begin
                        it_load_s = 1'b1;
                        state_d   = S_ITER;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    busy_d = 1'b0;
                end
            end
            S_ITER: begin
                it_step_s = 1'b1;
                if (it_last_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_ITER;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                lo_d    = res_lo_s;
                hi_d    = res_hi_s;
                carry_d = res_c_s;
                ovf_d   = res_v_s;
                zero_d  = res_z_s;
                dbz_d   = res_dz_s;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, operand and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= OP_ADD;
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            cin_q   <= 1'b0;
            neg_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            lo_q    <= {WIDTH{1'b0}};
            hi_q    <= {WIDTH{1'b0}};
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            neg_q   <= neg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign result_lo   = lo_q;
    assign result_hi   = hi_q;
    assign carry       = carry_q;
    assign overflow    = ovf_q;
    assign zero        = zero_q;
    assign div_by_zero = dbz_q;

endmodule
